alu_muldiv_seq: RTL and testbench

- Parametrised successor to the single-cycle ALU, adding the full RV32M multiply/divide set.
- Simple ops (add, sub, logic, shifts, compares) complete in one cycle.
- MUL, MULH* and DIV/REM* run on an iterative radix-2 datapath that takes DATA_WIDTH cycles.
- Sits in the execute stage behind a start/busy/done handshake; the stall unit holds the pipeline while busy is high.

---
 rtl/alu_pkg.sv | 48 ++++
 rtl/muldiv_iter.sv | 81 ++++++++
 rtl/alu_muldiv_seq.sv | 193 +++++++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcode and state encodings, FIX-stage control, op classifiers.
package alu_pkg;

    typedef enum logic [4:0] {
        OP_ADD    = 5'h00,
        OP_SUB    = 5'h01,
        OP_AND    = 5'h02,
        OP_OR     = 5'h03,
        OP_XOR    = 5'h04,
        OP_SLL    = 5'h05,
        OP_SRL    = 5'h06,
        OP_SRA    = 5'h07,
        OP_SLT    = 5'h08,
        OP_SLTU   = 5'h09,
        OP_MUL    = 5'h0A,
        OP_MULH   = 5'h0B,
        OP_MULHSU = 5'h0C,
        OP_MULHU  = 5'h0D,
        OP_DIV    = 5'h0E,
        OP_DIVU   = 5'h0F,
        OP_REM    = 5'h10,
        OP_REMU   = 5'h11
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_FIX,
        S_DONE
    } alu_state_e;

    // Captured at accept; tells FIX how to sign-correct and which half to keep.
    typedef struct packed {
        logic div_op;
        logic sel_hi;
        logic neg_main;
        logic neg_rem;
    } fix_ctl_t;

    function automatic logic is_iterative(input logic [4:0] op);
        return (op >= 5'h0A) && (op <= 5'h11);
    endfunction

    function automatic logic is_div(input logic [4:0] op);
        return (op >= 5'h0E) && (op <= 5'h11);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Radix-2 iterative datapath shared by multiply (shift-add) and divide (restoring).
// hi/lo form one 2*W shift register: product on multiply, remainder/quotient on divide.
module muldiv_iter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_W      = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  load,
    input  logic                  step,
    input  logic                  div_mode,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo,
    output logic                  last_c
);

    localparam int unsigned W = DATA_WIDTH;

    logic [W-1:0]     hi_q, hi_d;
    logic [W-1:0]     lo_q, lo_d;
    logic [W-1:0]     b_q, b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [W:0]       sum_c;
    logic [W:0]       rem_part_c;
    logic             fits_c;

    always_comb begin
        hi_d  = hi_q;
        lo_d  = lo_q;
        b_d   = b_q;
        cnt_d = cnt_q;

        sum_c      = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        rem_part_c = {hi_q, lo_q[W-1]};
        fits_c     = (rem_part_c >= {1'b0, b_q});

        if (clear) begin
            hi_d  = '0;
            lo_d  = '0;
            b_d   = '0;
            cnt_d = '0;
        end else if (load) begin
            hi_d  = '0;
            lo_d  = op_a;
            b_d   = op_b;
            cnt_d = '0;
        end else if (step) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (div_mode) begin
                // A fitting trial always leaves a remainder below the divisor, so W bits suffice.
                hi_d = fits_c ? (rem_part_c[W-1:0] - b_q) : rem_part_c[W-1:0];
                lo_d = {lo_q[W-2:0], fits_c};
            end else begin
                {hi_d, lo_d} = {sum_c, lo_q[W-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q  <= '0;
            lo_q  <= '0;
            b_q   <= '0;
            cnt_q <= '0;
        end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            b_q   <= b_d;
            cnt_q <= cnt_d;
        end
    end

    assign hi     = hi_q;
    assign lo     = lo_q;
    assign last_c = (cnt_q == CNT_W'(W - 1));

endmodule

// File: rtl/alu_muldiv_seq.sv
// Execute-stage ALU: single-cycle integer ops plus iterative RV32M multiply/divide
// behind a start/busy/done handshake.
module alu_muldiv_seq
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned SHAMT_W    = $clog2(DATA_WIDTH),
    parameter int unsigned CNT_W      = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  flush,
    input  logic [4:0]            ALUControl,
    input  logic [DATA_WIDTH-1:0] ALUop1,
    input  logic [DATA_WIDTH-1:0] ALUop2,
    output logic [DATA_WIDTH-1:0] ALUout,
    output logic                  EQ,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned W       = DATA_WIDTH;
    localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

    alu_state_e     state_q, state_d;
    logic [W-1:0]   alu_out_q, alu_out_d;
    logic           eq_q, eq_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    fix_ctl_t       ctl_q, ctl_d;

    alu_op_e        op_c;
    logic [W-1:0]   simple_c;
    logic [W-1:0]   fast_c;
    logic           div_zero_c, div_ovf_c, fast_path_c;
    logic           sign_a_c, sign_b_c;
    logic [W-1:0]   abs_a_c, abs_b_c;
    fix_ctl_t       ctl_new_c;
    logic [2*W-1:0] prod_c;
    logic [W-1:0]   quo_c, rem_c, fix_c;
    logic           load_c, step_c;

    logic [W-1:0]   md_hi, md_lo;
    logic           md_last_c;

    assign op_c = alu_op_e'(ALUControl);

    // Single-cycle ops; undefined opcodes yield zero.
    always_comb begin
        simple_c = '0;
        case (op_c)
            OP_ADD:  simple_c = ALUop1 + ALUop2;
            OP_SUB:  simple_c = ALUop1 - ALUop2;
            OP_AND:  simple_c = ALUop1 & ALUop2;
            OP_OR:   simple_c = ALUop1 | ALUop2;
            OP_XOR:  simple_c = ALUop1 ^ ALUop2;
            OP_SLL:  simple_c = ALUop1 << ALUop2[SHAMT_W-1:0];
            OP_SRL:  simple_c = ALUop1 >> ALUop2[SHAMT_W-1:0];
            OP_SRA:  simple_c = $unsigned($signed(ALUop1) >>> ALUop2[SHAMT_W-1:0]);
            OP_SLT:  simple_c = {{(W-1){1'b0}}, ($signed(ALUop1) < $signed(ALUop2))};
            OP_SLTU: simple_c = {{(W-1){1'b0}}, (ALUop1 < ALUop2)};
            default: simple_c = '0;
        endcase
    end

    // Divide corner cases resolved without iterating.
    always_comb begin
        div_zero_c  = (ALUop2 == '0);
        div_ovf_c   = ((op_c == OP_DIV) || (op_c == OP_REM)) &&
                      (ALUop1 == MIN_VAL) && (ALUop2 == '1);
        fast_path_c = is_div(ALUControl) && (div_zero_c || div_ovf_c);
        case (op_c)
            OP_DIV, OP_DIVU: fast_c = div_zero_c ? '1 : MIN_VAL;
            OP_REM, OP_REMU: fast_c = div_zero_c ? ALUop1 : '0;
            default:         fast_c = '0;
        endcase
    end

    // Operand magnitudes and result-sign flags; MUL low half is sign-agnostic so it runs unsigned.
    always_comb begin
        sign_a_c = ALUop1[W-1] && (op_c inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
        sign_b_c = ALUop2[W-1] && (op_c inside {OP_MULH, OP_DIV, OP_REM});
        abs_a_c  = sign_a_c ? -ALUop1 : ALUop1;
        abs_b_c  = sign_b_c ? -ALUop2 : ALUop2;
        ctl_new_c.div_op   = is_div(ALUControl);
        ctl_new_c.sel_hi   = op_c inside {OP_MULH, OP_MULHSU, OP_MULHU, OP_REM, OP_REMU};
        ctl_new_c.neg_main = sign_a_c ^ sign_b_c;
        ctl_new_c.neg_rem  = sign_a_c;
    end

    // FIX stage: sign correction and half/quotient/remainder select.
    always_comb begin
        prod_c = ctl_q.neg_main ? -{md_hi, md_lo} : {md_hi, md_lo};
        quo_c  = ctl_q.neg_main ? -md_lo : md_lo;
        rem_c  = ctl_q.neg_rem  ? -md_hi : md_hi;
        if (ctl_q.div_op) begin
            fix_c = ctl_q.sel_hi ? rem_c : quo_c;
        end else begin
            fix_c = ctl_q.sel_hi ? prod_c[2*W-1:W] : prod_c[W-1:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        alu_out_d = alu_out_q;
        eq_d      = eq_q;
        ctl_d     = ctl_q;
        load_c    = 1'b0;
        step_c    = 1'b0;

        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (is_iterative(ALUControl) && !fast_path_c) begin
                            state_d = S_ITER;
                            load_c  = 1'b1;
                            ctl_d   = ctl_new_c;
                        end else begin
                            state_d   = S_DONE;
                            alu_out_d = is_iterative(ALUControl) ? fast_c : simple_c;
                            eq_d      = (alu_out_d == '0);
                        end
                    end
                end
                S_ITER: begin
                    step_c = 1'b1;
                    if (md_last_c) begin
                        state_d = S_FIX;
                    end
                end
                S_FIX: begin
                    state_d   = S_DONE;
                    alu_out_d = fix_c;
                    eq_d      = (fix_c == '0);
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d == S_ITER) || (state_d == S_FIX);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            alu_out_q <= '0;
            eq_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ctl_q     <= '0;
        end else begin
            state_q   <= state_d;
            alu_out_q <= alu_out_d;
            eq_q      <= eq_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ctl_q     <= ctl_d;
        end
    end

    muldiv_iter #(
        .DATA_WIDTH (W),
        .CNT_W      (CNT_W)
    ) u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (flush),
        .load     (load_c),
        .step     (step_c),
        .div_mode (ctl_q.div_op),
        .op_a     (abs_a_c),
        .op_b     (abs_b_c),
        .hi       (md_hi),
        .lo       (md_lo),
        .last_c   (md_last_c)
    );

    assign ALUout = alu_out_q;
    assign EQ     = eq_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq: directed corner cases plus randomized ops
// compared every cycle against a cycle-count reference model.
module tb_alu_muldiv_seq;

    localparam logic [31:0] MIN  = 32'h8000_0000;
    localparam logic [31:0] ONES = 32'hFFFF_FFFF;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        flush;
    logic [4:0]  ALUControl;
    logic [31:0] ALUop1;
    logic [31:0] ALUop2;
    logic [31:0] ALUout;
    logic        EQ;
    logic        busy;
    logic        done;

    alu_muldiv_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .flush      (flush),
        .ALUControl (ALUControl),
        .ALUop1     (ALUop1),
        .ALUop2     (ALUop2),
        .ALUout     (ALUout),
        .EQ         (EQ),
        .busy       (busy),
        .done       (done)
    );

    int n_assert = 0;
    int n_fail   = 0;
    bit cmp_on   = 0;

    // Reference model state: absolute cycle index of the pending done pulse.
    int          cyc       = 0;
    bit          m_active  = 0;
    int          m_done_at = 0;
    logic [31:0] m_pend    = '0;
    logic [31:0] m_out     = '0;

    function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] ref_result(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ubs, pp;
        logic [63:0]        ua, ub, up;
        logic [31:0]        r;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        ubs = ub;
        r   = '0;
        case (op)
            5'd0:  r = a + b;
            5'd1:  r = a - b;
            5'd2:  r = a & b;
            5'd3:  r = a | b;
            5'd4:  r = a ^ b;
            5'd5:  r = a << b[4:0];
            5'd6:  r = a >> b[4:0];
            5'd7:  begin pp = sa >>> b[4:0]; r = pp[31:0]; end
            5'd8:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'd9:  r = (a < b) ? 32'd1 : 32'd0;
            5'd10: begin up = ua * ub; r = up[31:0]; end
            5'd11: begin pp = sa * sb; r = pp[63:32]; end
            5'd12: begin pp = sa * ubs; r = pp[63:32]; end
            5'd13: begin up = ua * ub; r = up[63:32]; end
            5'd14: begin
                if (b == 0)                    r = ONES;
                else if (a == MIN && b == ONES) r = MIN;
                else                           r = $signed(a) / $signed(b);
            end
            5'd15: r = (b == 0) ? ONES : a / b;
            5'd16: begin
                if (b == 0)                    r = a;
                else if (a == MIN && b == ONES) r = 32'd0;
                else                           r = $signed(a) % $signed(b);
            end
            5'd17: r = (b == 0) ? a : a % b;
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic int ref_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op < 5'd10 || op > 5'd17) return 1;
        if (op >= 5'd14 && b == 0) return 1;
        if ((op == 5'd14 || op == 5'd16) && a == MIN && b == ONES) return 1;
        return 34;
    endfunction

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return ONES;
            3:       return MIN;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Reference model update at each active edge (and on async reset).
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_active = 0;
                m_out    = '0;
            end else begin
                if (flush) begin
                    m_active = 0;
                end else if (start && !(m_active && cyc <= m_done_at)) begin
                    m_active  = 1;
                    m_done_at = cyc + ref_lat(ALUControl, ALUop1, ALUop2);
                    m_pend    = ref_result(ALUControl, ALUop1, ALUop2);
                end
                cyc++;
                if (m_active && cyc == m_done_at) m_out = m_pend;
            end
        end
    end

    // Per-cycle compare of all outputs against the model.
    initial begin
        wait (cmp_on);
        forever begin
            @(negedge clk);
            check("cyc_busy", 64'(busy), 64'(m_active && cyc < m_done_at));
            check("cyc_done", 64'(done), 64'(m_active && cyc == m_done_at));
            check("cyc_out", 64'(ALUout), 64'(m_out));
            check("cyc_eq", 64'(EQ), 64'(m_out == 32'd0));
        end
    end

    task automatic run_op(input string nm, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_lat, input int poke_at, input bit poke_done);
        int n, nb;
        check({nm, "_model"}, 64'(ref_result(op, a, b)), 64'(exp_res));
        ALUControl = op; ALUop1 = a; ALUop2 = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 1; nb = 0;
        while (!done && n < 80) begin
            if (n == poke_at) begin
                start = 1'b1; ALUControl = 5'd0; ALUop1 = 32'd1; ALUop2 = 32'd1;
            end
            if (busy) nb++;
            @(posedge clk); #1;
            start = 1'b0;
            n++;
        end
        check({nm, "_done"}, 64'(done), 64'd1);
        check({nm, "_lat"}, 64'(n), 64'(exp_lat));
        check({nm, "_busy"}, 64'(nb), 64'(exp_lat - 1));
        check({nm, "_res"}, 64'(ALUout), 64'(exp_res));
        check({nm, "_eq"}, 64'(EQ), 64'(exp_res == 32'd0));
        if (poke_done) begin
            start = 1'b1; ALUControl = 5'd0; ALUop1 = 32'd40; ALUop2 = 32'd2;
        end
        @(posedge clk); #1;
        start = 1'b0;
        if (poke_done) begin
            check({nm, "_done_start_ignored"}, 64'(done), 64'd0);
            check({nm, "_done_start_keep"}, 64'(ALUout), 64'(exp_res));
        end
    endtask

    initial begin
        int   n, kill_at, mode, lat;
        bit   killed;
        logic [4:0]  op;
        logic [31:0] a, b;

        rst_n = 1'b1; start = 1'b0; flush = 1'b0;
        ALUControl = '0; ALUop1 = '0; ALUop2 = '0;
        #2 rst_n = 1'b0;
        cmp_on = 1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        check("reset_out", 64'(ALUout), 64'd0);
        check("reset_eq", 64'(EQ), 64'd1);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);

        run_op("add", 5'd0, 32'd7, 32'd5, 32'd12, 1, 0, 1);
        run_op("sub", 5'd1, 32'd5, 32'd5, 32'd0, 1, 0, 0);
        run_op("sra", 5'd7, MIN, 32'd4, 32'hF800_0000, 1, 0, 0);
        run_op("sll", 5'd5, 32'd1, 32'd33, 32'd2, 1, 0, 0);
        run_op("slt", 5'd8, ONES, 32'd1, 32'd1, 1, 0, 0);
        run_op("sltu", 5'd9, ONES, 32'd1, 32'd0, 1, 0, 0);
        run_op("mulhu", 5'd13, ONES, ONES, 32'hFFFF_FFFE, 34, 0, 0);
        run_op("mul", 5'd10, ONES, ONES, 32'd1, 34, 0, 0);
        run_op("mulh", 5'd11, ONES, 32'd2, ONES, 34, 0, 0);
        run_op("mulhsu", 5'd12, ONES, ONES, ONES, 34, 0, 0);
        run_op("div", 5'd14, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 0, 0);
        run_op("rem", 5'd16, 32'hFFFF_FFF9, 32'd2, ONES, 34, 0, 0);
        run_op("divu", 5'd15, 32'd100, 32'd7, 32'd14, 34, 3, 0);
        run_op("remu", 5'd17, 32'd100, 32'd7, 32'd2, 34, 0, 0);
        run_op("divu_by0", 5'd15, 32'd9, 32'd0, ONES, 1, 0, 0);
        run_op("rem_by0", 5'd16, 32'd9, 32'd0, 32'd9, 1, 0, 0);
        run_op("div_ovf", 5'd14, MIN, ONES, MIN, 1, 0, 0);
        run_op("rem_ovf", 5'd16, MIN, ONES, 32'd0, 1, 0, 0);
        run_op("add42", 5'd0, 32'd20, 32'd22, 32'd42, 1, 0, 0);

        // Flush MULH at t+10.
        ALUControl = 5'd11; ALUop1 = 32'd3; ALUop2 = 32'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_done", 64'(done), 64'd0);
        check("flush_keep", 64'(ALUout), 64'd42);
        n = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done) n++;
        end
        check("flush_no_done", 64'(n), 64'd0);
        run_op("add_after_flush", 5'd0, 32'd1, 32'd1, 32'd2, 1, 0, 0);

        // Flush and start together in IDLE.
        ALUControl = 5'd0; ALUop1 = 32'd3; ALUop2 = 32'd3; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        check("flush_start_done", 64'(done), 64'd0);
        check("flush_start_keep", 64'(ALUout), 64'd2);

        // Async reset in the middle of a DIVU.
        ALUControl = 5'd15; ALUop1 = 32'd1000; ALUop2 = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        #1 rst_n = 1'b0;
        #1;
        check("midreset_out", 64'(ALUout), 64'd0);
        check("midreset_eq", 64'(EQ), 64'd1);
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_done", 64'(done), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Randomized ops with occasional flushes and ignored starts while busy.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 1) == 1) op = 5'($urandom_range(10, 17));
            else                           op = 5'($urandom_range(0, 31));
            a = pick_val();
            b = pick_val();
            lat = ref_lat(op, a, b);
            ALUControl = op; ALUop1 = a; ALUop2 = b; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            mode    = $urandom_range(0, 9);
            kill_at = (mode == 0) ? $urandom_range(1, 36) : -1;
            killed  = 0;
            n = 1;
            while (n < 60) begin
                if (done) break;
                if (n == kill_at) begin
                    flush = 1'b1;
                    @(posedge clk); #1;
                    flush = 1'b0;
                    killed = 1;
                    break;
                end
                if (mode == 1 && busy) begin
                    start = 1'b1; ALUControl = 5'($urandom); ALUop1 = $urandom; ALUop2 = $urandom;
                end
                @(posedge clk); #1;
                start = 1'b0;
                n++;
            end
            if (!killed) begin
                check("rnd_lat", 64'(n), 64'(lat));
                check("rnd_res", 64'(ALUout), 64'(ref_result(op, a, b)));
                @(posedge clk); #1;
            end
        end

        repeat (2) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
